alu_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one alu instance between two requesters (e.g. an integer issue port and a debug/test port).
- Accepts an operation from each requester over a valid/ready handshake and drives the alu's dataIn/ctrl/shamt/en_n.
- Waits a fixed alu latency, captures dataOut/hi/lo/status, and returns them to the winning requester over a second valid/ready handshake.
- Only one operation is in flight at a time.

---
 rtl/alu_arbiter_if.sv | 48 ++++
 rtl/alu_arbiter.sv | 109 ++++++++++
 tb/tb_alu_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response handshakes and alu-side connections of alu_arbiter.
// slave is the arbiter's view; master is the view of whoever sits around it.
interface alu_arbiter_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int CTRL_WIDTH   = 5,
   parameter int STATUS_WIDTH = 4,
   parameter int SHAMT_WIDTH  = 5
);
   logic [1:0]              reqValid;
   logic [1:0]              reqReady;
   logic [2*DATA_WIDTH-1:0] reqData0;
   logic [2*DATA_WIDTH-1:0] reqData1;
   logic [CTRL_WIDTH-1:0]   reqCtrl0;
   logic [CTRL_WIDTH-1:0]   reqCtrl1;
   logic [SHAMT_WIDTH-1:0]  reqShamt0;
   logic [SHAMT_WIDTH-1:0]  reqShamt1;
   logic [1:0]              respValid;
   logic [1:0]              respReady;
   logic [DATA_WIDTH-1:0]   respData;
   logic [DATA_WIDTH-1:0]   respHi;
   logic [DATA_WIDTH-1:0]   respLo;
   logic [STATUS_WIDTH-1:0] respStatus;
   logic                    busy;
   logic                    aluEn_n;
   logic [2*DATA_WIDTH-1:0] aluDataIn;
   logic [CTRL_WIDTH-1:0]   aluCtrl;
   logic [SHAMT_WIDTH-1:0]  aluShamt;
   logic [DATA_WIDTH-1:0]   aluDataOut;
   logic [DATA_WIDTH-1:0]   aluHi;
   logic [DATA_WIDTH-1:0]   aluLo;
   logic [STATUS_WIDTH-1:0] aluStatus;

   modport slave (
      input  reqValid, reqData0, reqData1, reqCtrl0, reqCtrl1, reqShamt0, reqShamt1,
      input  respReady,
      input  aluDataOut, aluHi, aluLo, aluStatus,
      output reqReady, respValid, respData, respHi, respLo, respStatus, busy,
      output aluEn_n, aluDataIn, aluCtrl, aluShamt
   );

   modport master (
      output reqValid, reqData0, reqData1, reqCtrl0, reqCtrl1, reqShamt0, reqShamt1,
      output respReady,
      output aluDataOut, aluHi, aluLo, aluStatus,
      input  reqReady, respValid, respData, respHi, respLo, respStatus, busy,
      input  aluEn_n, aluDataIn, aluCtrl, aluShamt
   );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one alu between two requesters: round-robin grant, issue, wait a
// fixed alu latency, capture the result and hand it back to the winner.
//
// state | meaning
// IDLE  | no operation in flight; grant a requester when any is valid
// ISSUE | operands on the alu, en_n low, latency counter loaded
// WAIT  | en_n held low for ALU_LATENCY cycles; capture alu outputs on the last
// RESP  | result presented to the winner until it accepts
module alu_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int CTRL_WIDTH   = 5,
   parameter int STATUS_WIDTH = 4,
   parameter int SHAMT_WIDTH  = 5,
   parameter int ALU_LATENCY  = 1
) (
   input logic          clk,
   input logic          rst,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [3:0] LAT_CNT = 4'(ALU_LATENCY);

   state_t     state;
   logic       rr_ptr;
   logic       gnt_id;
   logic [3:0] cnt;
   logic [1:0] arb;
   logic [1:0] gnt;

   // Pick a winner among valid requesters; rr_ptr only matters on contention
   always_comb begin
      arb = 2'b00;
      case (bus.reqValid)
         2'b01:   arb = 2'b01;
         2'b10:   arb = 2'b10;
         2'b11:   arb = rr_ptr ? 2'b10 : 2'b01;
         default: arb = 2'b00;
      endcase
   end

   // Ready is suppressed while rst is high so nothing is accepted into a reset
   assign gnt          = (state == IDLE && !rst) ? arb : 2'b00;
   assign bus.reqReady = gnt;
   assign bus.busy     = (state != IDLE);

   // Sequencer: grant, issue, count down the alu latency, return the result
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         rr_ptr         <= 1'b0;
         gnt_id         <= 1'b0;
         cnt            <= 4'd0;
         bus.respValid  <= 2'b00;
         bus.aluEn_n    <= 1'b1;
         bus.aluDataIn  <= {(2*DATA_WIDTH){1'b0}};
         bus.aluCtrl    <= {CTRL_WIDTH{1'b0}};
         bus.aluShamt   <= {SHAMT_WIDTH{1'b0}};
         bus.respData   <= {DATA_WIDTH{1'b0}};
         bus.respHi     <= {DATA_WIDTH{1'b0}};
         bus.respLo     <= {DATA_WIDTH{1'b0}};
         bus.respStatus <= {STATUS_WIDTH{1'b0}};
      end else begin
         case (state)
            IDLE: begin
               if (gnt != 2'b00) begin
                  // The alu input registers double as the request latch
                  gnt_id      <= gnt[1];
                  bus.aluDataIn <= gnt[1] ? bus.reqData1  : bus.reqData0;
                  bus.aluCtrl   <= gnt[1] ? bus.reqCtrl1  : bus.reqCtrl0;
                  bus.aluShamt  <= gnt[1] ? bus.reqShamt1 : bus.reqShamt0;
                  bus.aluEn_n <= 1'b0;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               cnt   <= LAT_CNT;
               state <= WAIT;
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  bus.respData   <= bus.aluDataOut;
                  bus.respHi     <= bus.aluHi;
                  bus.respLo     <= bus.aluLo;
                  bus.respStatus <= bus.aluStatus;
                  bus.respValid  <= gnt_id ? 2'b10 : 2'b01;
                  bus.aluEn_n    <= 1'b1;
                  state          <= RESP;
               end
            end
            RESP: begin
               // respReady of the other requester cannot complete this
               if ((bus.respValid & bus.respReady) != 2'b00) begin
                  rr_ptr        <= ~gnt_id;
                  bus.respValid <= 2'b00;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: three instances (ALU_LATENCY 1, 3, 4), each wired to a
// behavioural alu that only shows valid results once en_n has been low for
// ALU_LATENCY cycles. Expected results are queued at request acceptance and
// checked when the response appears.
module tb_alu_arbiter;
   typedef struct packed {
      logic [31:0] data;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [3:0]  status;
   } res_t;

   typedef struct {
      logic [63:0] data;
      logic [4:0]  ctrl;
      logic [4:0]  shamt;
      res_t        exp;
   } op_t;

   typedef struct {
      logic req;
      res_t exp;
   } sb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int          sel = 0;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  resp_ready_v = 2'b11;
   logic [63:0] req_data0 = '0, req_data1 = '0;
   logic [4:0]  req_ctrl0 = '0, req_ctrl1 = '0;
   logic [4:0]  req_shamt0 = '0, req_shamt1 = '0;

   logic [2:0][1:0]  req_ready;
   logic [2:0][1:0]  resp_valid;
   logic [2:0][31:0] resp_data;
   logic [2:0][31:0] resp_hi;
   logic [2:0][31:0] resp_lo;
   logic [2:0][3:0]  resp_status;
   logic [2:0]       busy;
   logic [2:0]       alu_en_n;

   function automatic logic [3:0] status_of(input logic [31:0] v);
      return {v == 32'd0, v[31], 2'b10};
   endfunction

   // Behavioural alu: 0 and, 1 or, 4 add, 6 mult, 8 srl of b, else xor
   function automatic res_t alu_ref(input logic [4:0] c, input logic [63:0] d,
                                    input logic [4:0] s);
      res_t        r;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p;
      a = d[63:32];
      b = d[31:0];
      p = {32'd0, a} * {32'd0, b};
      case (c)
         5'h0:    r.data = a & b;
         5'h1:    r.data = a | b;
         5'h4:    r.data = a + b;
         5'h6:    r.data = p[31:0];
         5'h8:    r.data = b >> s;
         default: r.data = a ^ b;
      endcase
      r.hi     = p[63:32];
      r.lo     = p[31:0];
      r.status = status_of(r.data);
      return r;
   endfunction

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int LAT = (k == 0) ? 1 : ((k == 1) ? 3 : 4);
      alu_arbiter_if #(.DATA_WIDTH(32), .CTRL_WIDTH(5), .STATUS_WIDTH(4), .SHAMT_WIDTH(5)) bus ();
      logic [3:0] en_cnt = 4'd0;
      logic       alu_ok;
      res_t       r;

      assign bus.reqValid  = (sel == k) ? req_valid : 2'b00;
      assign bus.respReady = (sel == k) ? resp_ready_v : 2'b00;
      assign bus.reqData0  = req_data0;
      assign bus.reqData1  = req_data1;
      assign bus.reqCtrl0  = req_ctrl0;
      assign bus.reqCtrl1  = req_ctrl1;
      assign bus.reqShamt0 = req_shamt0;
      assign bus.reqShamt1 = req_shamt1;

      always @(posedge clk)
         en_cnt <= bus.aluEn_n ? 4'd0 : ((en_cnt == 4'hF) ? en_cnt : en_cnt + 4'd1);

      assign r              = alu_ref(bus.aluCtrl, bus.aluDataIn, bus.aluShamt);
      assign alu_ok         = !bus.aluEn_n && (en_cnt >= 4'(LAT));
      assign bus.aluDataOut = alu_ok ? r.data   : 32'hDEADBEEF;
      assign bus.aluHi      = alu_ok ? r.hi     : 32'hBAD0BAD0;
      assign bus.aluLo      = alu_ok ? r.lo     : 32'h0BADF00D;
      assign bus.aluStatus  = alu_ok ? r.status : 4'h5;

      alu_arbiter #(
         .DATA_WIDTH(32), .CTRL_WIDTH(5), .STATUS_WIDTH(4), .SHAMT_WIDTH(5), .ALU_LATENCY(LAT)
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .bus(bus.slave)
      );

      assign req_ready[k]   = bus.reqReady;
      assign resp_valid[k]  = bus.respValid;
      assign resp_data[k]   = bus.respData;
      assign resp_hi[k]     = bus.respHi;
      assign resp_lo[k]     = bus.respLo;
      assign resp_status[k] = bus.respStatus;
      assign busy[k]        = bus.busy;
      assign alu_en_n[k]    = bus.aluEn_n;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   op_t        pend0[$];
   op_t        pend1[$];
   sb_t        sb[$];
   logic       model_rr = 1'b0;
   int         stall[2] = '{0, 0};
   int         cyc = 0;
   int         hs_cyc = 0;
   int         en_low = 0;
   bit         in_resp = 1'b0;
   res_t       held;
   logic [1:0] held_v;
   logic [3:0] glog = 4'd0;
   int         gnt_cyc[2] = '{0, 0};
   int         resp_cyc[2] = '{0, 0};
   logic [4:0] rnd_ops[6] = '{5'h0, 5'h1, 5'h4, 5'h6, 5'h8, 5'h3};

   function automatic int lat_of(input int k);
      case (k)
         0:       return 1;
         1:       return 3;
         default: return 4;
      endcase
   endfunction

   function automatic logic get_rr(input int k);
      case (k)
         0:       return g_dut[0].u_dut.rr_ptr;
         1:       return g_dut[1].u_dut.rr_ptr;
         default: return g_dut[2].u_dut.rr_ptr;
      endcase
   endfunction

   function automatic op_t mk(input logic [4:0] c, input logic [63:0] d, input logic [4:0] s);
      op_t o;
      o.ctrl  = c;
      o.data  = d;
      o.shamt = s;
      o.exp   = alu_ref(c, d, s);
      return o;
   endfunction

   task automatic drive();
      req_valid = {pend1.size() != 0, pend0.size() != 0};
      if (pend0.size() != 0) begin
         req_data0  = pend0[0].data;
         req_ctrl0  = pend0[0].ctrl;
         req_shamt0 = pend0[0].shamt;
      end
      if (pend1.size() != 0) begin
         req_data1  = pend1[0].data;
         req_ctrl1  = pend1[0].ctrl;
         req_shamt1 = pend1[0].shamt;
      end
      resp_ready_v = {stall[1] == 0, stall[0] == 0};
   endtask

   // One clock: observe at negedge, advance, then update inputs after the edge
   task automatic step();
      sb_t        e;
      op_t        o;
      logic [1:0] hs;
      logic [1:0] exp_g;
      logic [1:0] rv;
      @(negedge clk);
      cyc++;
      rv = resp_valid[sel];
      if (!alu_en_n[sel]) en_low++;
      if (busy[sel]) chk("ready_busy", 64'(req_ready[sel]), 64'd0);
      else if (req_valid != 2'b00 && !rst) begin
         exp_g = (req_valid == 2'b11) ? (model_rr ? 2'b10 : 2'b01) : req_valid;
         chk("grant", 64'(req_ready[sel]), 64'(exp_g));
      end
      hs = req_valid & req_ready[sel];
      if (hs != 2'b00) begin
         if (hs[1]) o = pend1.pop_front();
         else       o = pend0.pop_front();
         e.req = hs[1];
         e.exp = o.exp;
         sb.push_back(e);
         hs_cyc = cyc;
         en_low = 0;
         glog   = {glog[2:0], hs[1]};
         gnt_cyc[int'(hs[1])] = cyc;
      end
      if (rv != 2'b00) begin
         if (sb.size() == 0) chk("resp_unexpected", 64'(rv), 64'd0);
         else begin
            if (!in_resp) begin
               in_resp = 1'b1;
               chk("latency", 64'(cyc - hs_cyc), 64'(lat_of(sel) + 2));
               chk("en_low_cycles", 64'(en_low), 64'(lat_of(sel) + 1));
               chk("busy_resp", 64'(busy[sel]), 64'd1);
               chk("resp_who", 64'(rv), sb[0].req ? 64'd2 : 64'd1);
               chk("resp_data", 64'(resp_data[sel]), 64'(sb[0].exp.data));
               chk("resp_hi", 64'(resp_hi[sel]), 64'(sb[0].exp.hi));
               chk("resp_lo", 64'(resp_lo[sel]), 64'(sb[0].exp.lo));
               chk("resp_status", 64'(resp_status[sel]), 64'(sb[0].exp.status));
               held   = '{resp_data[sel], resp_hi[sel], resp_lo[sel], resp_status[sel]};
               held_v = rv;
            end else begin
               chk("hold_valid", 64'(rv), 64'(held_v));
               chk("hold_data", {28'd0, resp_data[sel], resp_status[sel]}, {28'd0, held.data, held.status});
               chk("hold_hilo", {resp_hi[sel], resp_lo[sel]}, {held.hi, held.lo});
            end
            if ((rv & resp_ready_v) != 2'b00) begin
               resp_cyc[int'(sb[0].req)] = cyc;
               model_rr = ~sb[0].req;
               void'(sb.pop_front());
               in_resp = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++)
         if (in_resp && sb.size() != 0 && int'(sb[0].req) == i && stall[i] > 0) stall[i]--;
      drive();
   endtask

   task automatic run_idle(input int budget);
      int n;
      n = 0;
      while ((pend0.size() != 0 || pend1.size() != 0 || sb.size() != 0) && n < budget) begin
         step();
         n++;
      end
      chk("drain_timeout", 64'(pend0.size() + pend1.size() + sb.size()), 64'd0);
      step();
      step();
   endtask

   // One-cycle reset of every instance; any in-flight result is abandoned
   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
      in_resp  = 1'b0;
      model_rr = 1'b0;
      en_low   = 0;
      stall    = '{0, 0};
      drive();
      chk("rst_busy", 64'(busy[sel]), 64'd0);
      chk("rst_en_n", 64'(alu_en_n[sel]), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid[sel]), 64'd0);
      chk("rst_rr_ptr", 64'(get_rr(sel)), 64'd0);
   endtask

   initial begin
      op_t o;
      drive();
      repeat (3) @(posedge clk);
      #1;
      // Requests presented while reset is held must not be accepted
      req_valid = 2'b11;
      #1;
      chk("rst_ready", 64'(req_ready[0]), 64'd0);
      chk("rst_busy0", 64'(busy[0]), 64'd0);
      chk("rst_en_n0", 64'(alu_en_n[0]), 64'd1);
      chk("rst_resp_valid0", 64'(resp_valid[0]), 64'd0);
      chk("rst_resp_regs", {28'd0, resp_data[0], resp_status[0]}, 64'd0);
      chk("rst_resp_hilo", {resp_hi[0], resp_lo[0]}, 64'd0);
      chk("rst_alu_in", g_dut[0].bus.aluDataIn, 64'd0);
      chk("rst_alu_ctrl", {54'd0, g_dut[0].bus.aluCtrl, g_dut[0].bus.aluShamt}, 64'd0);
      req_valid = 2'b00;
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive();

      // Single add, latency 1
      sel = 0;
      o = mk(5'h4, 64'hF0000001F0000001, 5'd0);
      o.exp.data   = 32'hE0000002;
      o.exp.status = status_of(32'hE0000002);
      pend0.push_back(o);
      drive();
      run_idle(50);

      // Contention: both valid throughout, grants alternate starting with 0
      do_reset();
      glog = 4'd0;
      o = mk(5'h0, 64'h0FFFFFFF000FFFFF, 5'd0);
      o.exp.data   = 32'h000FFFFF;
      o.exp.status = status_of(32'h000FFFFF);
      pend0.push_back(o);
      pend0.push_back(o);
      o = mk(5'h1, 64'h0FFFFFFF000FFFFF, 5'd0);
      o.exp.data   = 32'h0FFFFFFF;
      o.exp.status = status_of(32'h0FFFFFFF);
      pend1.push_back(o);
      pend1.push_back(o);
      drive();
      run_idle(100);
      chk("grant_order", 64'(glog), 64'h5);

      // Mult: hi/lo carry the product
      o = mk(5'h6, 64'h0000000600000002, 5'd0);
      o.exp.hi = 32'h00000000;
      o.exp.lo = 32'h0000000C;
      pend1.push_back(o);
      drive();
      run_idle(50);

      // Backpressure on requester 0 while requester 1 waits; latency 3
      sel = 1;
      do_reset();
      pend0.push_back(mk(5'h4, 64'h1234567800000011, 5'd0));
      drive();
      step();
      stall[0] = 5;
      pend1.push_back(mk(5'h1, 64'h00FF00FF0F0F0F0F, 5'd0));
      drive();
      run_idle(100);
      chk("bp_grant_after_resp", 64'(gnt_cyc[1] - resp_cyc[0]), 64'd1);

      // Shift right logical with latency 3
      o = mk(5'h8, 64'h0000000CC0000001, 5'd1);
      o.exp.data   = 32'h60000000;
      o.exp.status = status_of(32'h60000000);
      pend0.push_back(o);
      drive();
      run_idle(50);

      // Mixed traffic from both requesters
      for (int i = 0; i < 8; i++) begin
         o = mk(rnd_ops[$urandom_range(0, 5)], {$urandom(), $urandom()}, 5'($urandom_range(0, 31)));
         if ($urandom_range(0, 1) == 0) pend0.push_back(o);
         else                           pend1.push_back(o);
      end
      drive();
      run_idle(300);

      // Reset during WAIT with latency 4, after rr_ptr has moved to 1
      sel = 2;
      do_reset();
      pend0.push_back(mk(5'h4, 64'h0000000100000002, 5'd0));
      drive();
      run_idle(50);
      chk("rr_moved", 64'(get_rr(2)), 64'd1);
      pend1.push_back(mk(5'h4, 64'h0000000300000004, 5'd0));
      drive();
      step();
      step();
      step();
      chk("pre_rst_busy", 64'(busy[2]), 64'd1);
      chk("pre_rst_en_n", 64'(alu_en_n[2]), 64'd0);
      do_reset();
      repeat (12) step();
      chk("aborted_no_resp", 64'(resp_valid[2]), 64'd0);
      glog = 4'd0;
      pend0.push_back(mk(5'h1, 64'h0000F00000000F00, 5'd0));
      pend1.push_back(mk(5'h0, 64'h0000F0000000FF00, 5'd0));
      drive();
      run_idle(100);
      chk("post_rst_order", 64'(glog[1:0]), 64'h1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
